ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
AHB-Lite responder that pairs with the team's AHB master. It decodes its slot on the 2-bit select bus and services single read and write transfers into an internal word-organised RAM. It supports byte, halfword and word sizes, a programmable number of wait states, and the two-cycle ERROR response. The block sits between the master's address/control/write-data outputs and the hreadyout/hresp/hrdata return path.

Parameters:
SLAVE_ID, 2'b00, value of sel that selects this slave
ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W words of 32 bits
WAIT_CYCLES, 0, wait states inserted per accepted transfer (0..15)

Ports:
hclk  in  1  clock; all logic on rising edge
hreset  in  1  synchronous, active-high reset
sel  in  2  slave select; this slave is selected when sel == SLAVE_ID
haddr  in  32  byte address (address phase)
hwrite  in  1  1 = write, 0 = read
hsize  in  3  0 = byte, 1 = half, 2 = word
hburst  in  3  ignored; every transfer is treated as SINGLE
hprot  in  4  protection; used only by the optional feature
htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
hmastlock  in  1  ignored
hready  in  1  bus ready; an address phase is accepted only when this is 1
hwdata  in  32  write data (data phase)
hreadyout  out  1  slave ready
hresp  out  1  0 OKAY, 1 ERROR
hrdata  out  32  read data

Behaviour:
- Reset (hreset = 1 at a rising edge): hreadyout = 1, hresp = 0, hrdata = 0, FSM goes to IDLE, latched control is cleared. RAM contents are not reset.
- Accept condition at an edge: sel == SLAVE_ID, hready = 1 and htrans[1] = 1. IDLE and BUSY transfers get a zero-wait OKAY and have no side effects.
- On acceptance, latch: word address haddr[ADDR_W+1:2], byte offset haddr[1:0], hsize and hwrite.
- Error check at acceptance. A transfer is an error if any of these holds:
  - hsize > 2
  - misaligned access (half with haddr[0] = 1; word with haddr[1:0] != 0)
  - haddr[31:ADDR_W+2] != 0
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on an error acceptance go to ERR1. On a good acceptance go to WAIT if WAIT_CYCLES > 0, else DATA.
  - WAIT: hreadyout = 0. A counter loads WAIT_CYCLES-1 and decrements; at 0, go to DATA.
  - DATA: hreadyout = 1, hresp = 0; the transfer completes at this edge.
    - Write: commit hwdata byte lanes to RAM.
    - The next transfer may be accepted at the same edge (pipelined), with transitions as from IDLE; otherwise go to IDLE.
  - ERR1: hreadyout = 0, hresp = 1; go to ERR2.
  - ERR2: hreadyout = 1, hresp = 1. A new transfer may be accepted, as in DATA.
- Byte lanes: byte writes lane = offset; half writes lanes {offset+1, offset}; word writes all 4 lanes. Unwritten lanes are preserved.
- Read data is registered. hrdata is loaded from RAM at the edge entering the data phase, and is valid whenever hreadyout = 1 in DATA.
  - It is the full 32-bit word; the master extracts the lanes.
  - hrdata holds its value outside read data phases.
- Write-then-read hazard: a read accepted at the same edge as a write commit to the same word returns the merged (new) word. There is no stall.
- A new acceptance with WAIT_CYCLES = 0 gives zero-wait back-to-back throughput of one transfer per cycle.
- Reset asserted mid-transfer aborts it. Any pending write is discarded, and outputs return to reset values on the next edge.
- When sel no longer matches, hreadyout = 1 and hresp = 0 once any in-flight transfer has finished.

Optional Feature:
AHB_SLV_PROT_EN
- Defined: a transfer accepted with hprot[1] = 0 (user) whose word address MSB is 1 (upper half of RAM) is an error and takes the two-cycle ERROR path. Reads return no data; writes do not modify RAM.
- Not defined: hprot is ignored entirely.

Test Plan:
- Reset check: hold hreset for 2 cycles -> hreadyout = 1, hresp = 0, hrdata = 0x00000000.
- Word write then read, WAIT_CYCLES = 0: write 0xDEADBEEF to 0x10 (NONSEQ), then read 0x10 -> hreadyout never low; hrdata = 0xDEADBEEF in the read data phase.
- Byte and half lanes: word write 0x11223344 to 0x20, byte write 0xAA to 0x21, half write 0xBBCC to 0x22, then read 0x20 -> 0xBBCCAA44.
- Wait states, WAIT_CYCLES = 3: read 0x04 -> hreadyout low for exactly 3 cycles, then high with valid data.
- Errors, ADDR_W = 8:
  - word access to 0x00000402 -> ERR1 (hreadyout = 0, hresp = 1) then ERR2 (hreadyout = 1, hresp = 1); RAM unchanged.
  - address 0x00000400 -> same ERROR sequence.
- Pipelined hazard and select: write 0xCAFEF00D to 0x30 with a read of 0x30 in the following address phase -> hrdata = 0xCAFEF00D. A transfer with sel != SLAVE_ID -> no RAM change and OKAY; with AHB_SLV_PROT_EN, a user write to 0x200 -> ERROR.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite single-transfer RAM responder with wait states and ERROR response.
// Optional user/supervisor protection of the upper RAM half: AHB_SLV_PROT_EN.
module ahb_slave_mem #(
   parameter logic [1:0] SLAVE_ID    = 2'b00,
   parameter int         ADDR_W      = 8,
   parameter int         WAIT_CYCLES = 0
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic [1:0]  sel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic        hmastlock,
   input  logic        hready,
   input  logic [31:0] hwdata,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_e;

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [3:0] WLOAD =
      4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   logic [31:0] mem [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        size_q, size_d;
   logic              write_q, write_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       hrdata_q, hrdata_d;

   logic              can_acc;
   logic              acc;
   logic              err;
   logic              prot_err;
   logic              commit;
   logic              load_rd;
   logic [ADDR_W-1:0] a_word;
   logic [ADDR_W-1:0] rd_addr;
   logic [3:0]        be;
   logic [31:0]       old_word;
   logic [31:0]       wr_word;
   logic [31:0]       rd_word;
   logic              unused;

   assign unused = ^{hburst, hmastlock, hprot};
   assign a_word = haddr[ADDR_W+1:2];

`ifdef AHB_SLV_PROT_EN
   assign prot_err = !hprot[1] && a_word[ADDR_W-1];
`else
   assign prot_err = 1'b0;
`endif

   always_comb begin
      can_acc = (state_q == S_IDLE) || (state_q == S_DATA) ||
                (state_q == S_ERR2);
      acc = can_acc && (sel == SLAVE_ID) && hready && htrans[1];
      err = (hsize > 3'd2) ||
            ((hsize == 3'd1) && haddr[0]) ||
            ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) ||
            (haddr[31:ADDR_W+2] != '0) ||
            prot_err;
   end

   // Lane merge of the committing write, also used to forward to a read
   always_comb begin
      case (size_q)
         3'd0:    be = 4'b0001 << off_q;
         3'd1:    be = 4'b0011 << off_q;
         default: be = 4'b1111;
      endcase
      commit   = (state_q == S_DATA) && write_q;
      old_word = mem[addr_q];
      wr_word  = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) wr_word[i*8 +: 8] = hwdata[i*8 +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      off_d    = off_q;
      size_d   = size_q;
      write_d  = write_q;
      cnt_d    = cnt_q;
      hrdata_d = hrdata_q;
      load_rd  = 1'b0;
      rd_addr  = addr_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DATA;
               load_rd = !write_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            state_d = S_IDLE;
            if (acc) begin
               addr_d  = a_word;
               off_d   = haddr[1:0];
               size_d  = hsize;
               write_d = hwrite;
               if (err) begin
                  state_d = S_ERR1;
               end else if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WLOAD;
               end else begin
                  state_d = S_DATA;
                  load_rd = !hwrite;
                  rd_addr = a_word;
               end
            end
         end
      endcase
      rd_word = (commit && (rd_addr == addr_q)) ? wr_word : mem[rd_addr];
      if (load_rd) hrdata_d = rd_word;
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         off_q    <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         cnt_q    <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         off_q    <= off_d;
         size_q   <= size_d;
         write_q  <= write_d;
         cnt_q    <= cnt_d;
         hrdata_q <= hrdata_d;
      end
   end

   // RAM is not reset; a commit coinciding with reset is dropped
   always_ff @(posedge hclk) begin
      if (!hreset && commit) mem[addr_q] <= wr_word;
   end

   assign hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
   assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: zero-wait slave (sel 0), 3-wait slave (sel 1).
module tb_ahb_slave_mem;

`ifdef AHB_SLV_PROT_EN
   localparam logic PE = 1'b1;
`else
   localparam logic PE = 1'b0;
`endif
   localparam logic [3:0] PRV = 4'b0011;
   localparam logic [3:0] USR = 4'b0001;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic [1:0]  sel = 2'b11;
   logic [31:0] haddr = '0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd2;
   logic [2:0]  hburst = 3'd0;
   logic [3:0]  hprot = PRV;
   logic [1:0]  htrans = 2'b00;
   logic        hmastlock = 1'b0;
   logic [31:0] hwdata = '0;
   logic        ro0, rs0, ro3, rs3;
   logic [31:0] rd0, rd3;
   logic        bus_ready, bus_resp;
   logic [31:0] bus_rdata;

   int checks = 0;
   int failures = 0;

   assign bus_ready = ro0 & ro3;
   assign bus_resp  = rs0 | rs3;
   assign bus_rdata = (sel == 2'b01) ? rd3 : rd0;

   always #5 hclk = ~hclk;

   ahb_slave_mem #(.SLAVE_ID(2'b00), .ADDR_W(8), .WAIT_CYCLES(0)) u0 (
      .hclk(hclk), .hreset(hreset), .sel(sel), .haddr(haddr),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .htrans(htrans), .hmastlock(hmastlock), .hready(bus_ready),
      .hwdata(hwdata), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
   );

   ahb_slave_mem #(.SLAVE_ID(2'b01), .ADDR_W(8), .WAIT_CYCLES(3)) u3 (
      .hclk(hclk), .hreset(hreset), .sel(sel), .haddr(haddr),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .htrans(htrans), .hmastlock(hmastlock), .hready(bus_ready),
      .hwdata(hwdata), .hreadyout(ro3), .hresp(rs3), .hrdata(rd3)
   );

   typedef struct {
      logic [1:0]  s;
      logic [31:0] a;
      logic        w;
      logic [2:0]  sz;
      logic [3:0]  pr;
      logic [31:0] wd;
      logic        er;
      int          wt;
      logic        ck;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic [1:0] s, input logic [31:0] a,
                       input logic w, input logic [2:0] sz,
                       input logic [3:0] pr, input logic [31:0] wd,
                       output logic rsp, output logic rsp1,
                       output logic [31:0] rd, output int waits);
      @(negedge hclk);
      sel = s; haddr = a; hwrite = w; hsize = sz; hprot = pr;
      htrans = 2'b10;
      @(posedge hclk);
      @(negedge hclk);
      htrans = 2'b00; hwdata = wd;
      waits = 0;
      rsp1 = bus_resp;
      while (!bus_ready && waits < 40) begin
         waits++;
         @(negedge hclk);
      end
      rsp = bus_resp;
      rd = bus_rdata;
      @(posedge hclk);
   endtask

   initial begin
      logic rsp, rsp1;
      logic [31:0] rd;
      int wt;
      int n;

      tbl.push_back('{2'd0, 32'h10, 1, 3'd2, PRV, 32'hDEADBEEF, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h10, 0, 3'd2, PRV, 32'h0, 0, 0, 1, 32'hDEADBEEF});
      tbl.push_back('{2'd0, 32'h20, 1, 3'd2, PRV, 32'h11223344, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h21, 1, 3'd0, PRV, 32'h0000AA00, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h22, 1, 3'd1, PRV, 32'hBBCC0000, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h20, 0, 3'd2, PRV, 32'h0, 0, 0, 1, 32'hBBCCAA44});
      tbl.push_back('{2'd0, 32'h23, 1, 3'd0, PRV, 32'h77000000, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h20, 0, 3'd2, PRV, 32'h0, 0, 0, 1, 32'h77CCAA44});
      tbl.push_back('{2'd0, 32'h00, 1, 3'd2, PRV, 32'h01020304, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h402, 1, 3'd2, PRV, 32'h99999999, 1, 1, 0, 0});
      tbl.push_back('{2'd0, 32'h400, 1, 3'd2, PRV, 32'h99999999, 1, 1, 0, 0});
      tbl.push_back('{2'd0, 32'h00, 0, 3'd2, PRV, 32'h0, 0, 0, 1, 32'h01020304});
      tbl.push_back('{2'd0, 32'h21, 0, 3'd1, PRV, 32'h0, 1, 1, 0, 0});
      tbl.push_back('{2'd0, 32'h20, 0, 3'd3, PRV, 32'h0, 1, 1, 0, 0});
      tbl.push_back('{2'd2, 32'h10, 1, 3'd2, PRV, 32'h0BADF00D, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h10, 0, 3'd2, PRV, 32'h0, 0, 0, 1, 32'hDEADBEEF});
      tbl.push_back('{2'd1, 32'h04, 1, 3'd2, PRV, 32'hA5A5A5A5, 0, 3, 0, 0});
      tbl.push_back('{2'd1, 32'h04, 0, 3'd2, PRV, 32'h0, 0, 3, 1, 32'hA5A5A5A5});
      tbl.push_back('{2'd1, 32'h40, 1, 3'd2, PRV, 32'h55555555, 0, 3, 0, 0});
      tbl.push_back('{2'd1, 32'h03, 1, 3'd2, PRV, 32'hFFFFFFFF, 1, 1, 0, 0});
      tbl.push_back('{2'd1, 32'h04, 0, 3'd2, PRV, 32'h0, 0, 3, 1, 32'hA5A5A5A5});
      tbl.push_back('{2'd0, 32'h200, 1, 3'd2, PRV, 32'h34343434, 0, 0, 0, 0});
      tbl.push_back('{2'd0, 32'h200, 1, 3'd2, USR, 32'h12121212,
                      PE, PE ? 1 : 0, 0, 0});
      tbl.push_back('{2'd0, 32'h200, 0, 3'd2, PRV, 32'h0, 0, 0, 1,
                      PE ? 32'h34343434 : 32'h12121212});
      tbl.push_back('{2'd0, 32'h30, 1, 3'd2, PRV, 32'h12345678, 0, 0, 0, 0});

      repeat (2) @(posedge hclk);
      @(negedge hclk);
      chk("rst ready0", 32'(ro0), 32'd1);
      chk("rst resp0", 32'(rs0), 32'd0);
      chk("rst rdata0", rd0, 32'h0);
      chk("rst ready3", 32'(ro3), 32'd1);
      chk("rst resp3", 32'(rs3), 32'd0);
      chk("rst rdata3", rd3, 32'h0);
      hreset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         xfer(tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].sz, tbl[i].pr,
              tbl[i].wd, rsp, rsp1, rd, wt);
         chk($sformatf("v%0d resp", i), 32'(rsp), 32'(tbl[i].er));
         chk($sformatf("v%0d waits", i), 32'(wt), 32'(tbl[i].wt));
         if (tbl[i].er) chk($sformatf("v%0d err1", i), 32'(rsp1), 32'd1);
         if (tbl[i].ck) chk($sformatf("v%0d rdata", i), rd, tbl[i].rd);
      end

      // Pipelined write then read of the same word
      @(negedge hclk);
      sel = 2'b00; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
      hprot = PRV; htrans = 2'b10;
      @(posedge hclk);
      @(negedge hclk);
      chk("pipe w ready", 32'(bus_ready), 32'd1);
      hwdata = 32'hCAFEF00D; hwrite = 1'b0; htrans = 2'b10;
      @(posedge hclk);
      @(negedge hclk);
      htrans = 2'b00;
      chk("pipe r ready", 32'(bus_ready), 32'd1);
      chk("pipe r resp", 32'(bus_resp), 32'd0);
      chk("pipe r rdata", bus_rdata, 32'hCAFEF00D);
      @(posedge hclk);
      xfer(2'b00, 32'h30, 0, 3'd2, PRV, 32'h0, rsp, rsp1, rd, wt);
      chk("pipe readback", rd, 32'hCAFEF00D);

      // Reset during the data phase of a write on the wait-state slave
      @(negedge hclk);
      sel = 2'b01; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
      htrans = 2'b10;
      @(posedge hclk);
      @(negedge hclk);
      htrans = 2'b00; hwdata = 32'hFFFFFFFF;
      n = 0;
      while (!bus_ready && n < 20) begin
         n++;
         @(negedge hclk);
      end
      chk("abort waits", 32'(n), 32'd3);
      hreset = 1'b1;
      @(posedge hclk);
      @(negedge hclk);
      chk("abort ready3", 32'(ro3), 32'd1);
      chk("abort resp3", 32'(rs3), 32'd0);
      chk("abort rdata3", rd3, 32'h0);
      chk("abort rdata0", rd0, 32'h0);
      hreset = 1'b0;
      xfer(2'b01, 32'h40, 0, 3'd2, PRV, 32'h0, rsp, rsp1, rd, wt);
      chk("abort readback", rd, 32'h55555555);
      chk("abort rb waits", 32'(wt), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
